apb_mem_master: RTL and testbench



---
 rtl/mem_design_pkg.sv | 20 ++
 rtl/apb_mem_master_cmd_fifo.sv | 69 ++++++
 rtl/apb_mem_master.sv | 211 +++++++++++++++++++++
 tb/tb_apb_mem_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_design_pkg.sv
// ---------------------------------------------------------------------------
// mem_design_pkg
// Shared constants and types for the APB memory subsystem.
//   param_WIDTH_DATA / param_WIDTH_ADDR / param_SIZE : default bus geometry,
//     shared with the APB memory slave so master and slave always agree.
//   apb_mst_states : APB requester state encoding.
// ---------------------------------------------------------------------------
package mem_design_pkg;

   localparam int param_WIDTH_DATA = 32;
   localparam int param_WIDTH_ADDR = 8;
   localparam int param_SIZE       = 16;

   typedef enum logic [1:0] {
      apb_mst_idle,
      apb_mst_setup,
      apb_mst_access
   } apb_mst_states;

endpackage

// File: rtl/apb_mem_master_cmd_fifo.sv
// ---------------------------------------------------------------------------
// apb_cmd_fifo
// Synchronous show-ahead command FIFO: dout always presents the head entry,
// so the consumer samples dout in the same cycle it asserts pop.
// Ports:
//   PCLK, PRESETn : clock, synchronous active-low reset (control state only)
//   push, din     : write an entry (ignored when full)
//   pop, dout     : remove the head entry (ignored when empty)
//   full, empty   : occupancy flags
// ---------------------------------------------------------------------------
module apb_cmd_fifo
   import mem_design_pkg::*;
#(
   parameter int WIDTH = 1 + param_WIDTH_ADDR + param_WIDTH_DATA,
   parameter int DEPTH = 4
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             push,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; the separate
   // count disambiguates full from empty.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
      end
   end

   // Storage carries no reset; stale entries are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge PCLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/apb_mem_master.sv
// ---------------------------------------------------------------------------
// apb_mem_master
// APB requester feeding the APB memory slave. Commands arrive on a
// valid/ready port, are queued in apb_cmd_fifo, and each is issued as one
// SETUP+ACCESS transfer. The completed transfer is returned as a single
// response (read data + error) on a valid/ready port.
//
// Optional build macro: APB_MASTER_TIMEOUT_EN
//   Defined   : ACCESS is abandoned after TIMEOUT_CYCLES cycles without
//               PREADY, returning rsp_err=1, rsp_rdata=0.
//   Undefined : ACCESS waits for PREADY indefinitely.
//
// Ports:
//   PCLK, PRESETn                    : clock, synchronous active-low reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_write, cmd_addr, cmd_wdata   : command payload
//   rsp_valid/rsp_ready              : response handshake
//   rsp_write, rsp_rdata, rsp_err    : response payload
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PREADY, PRDATA           : APB requester bus
// ---------------------------------------------------------------------------
module apb_mem_master
   import mem_design_pkg::*;
#(
   parameter int WIDTH_DATA     = param_WIDTH_DATA,
   parameter int WIDTH_ADDR     = param_WIDTH_ADDR,
   parameter int SIZE           = param_SIZE,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [WIDTH_ADDR-1:0] cmd_addr,
   input  logic [WIDTH_DATA-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [WIDTH_DATA-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [WIDTH_ADDR-1:0] PADDR,
   output logic [WIDTH_DATA-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [WIDTH_DATA-1:0] PRDATA
);

   localparam int CMD_W = 1 + WIDTH_ADDR + WIDTH_DATA;
   localparam logic [WIDTH_ADDR:0] SIZE_EXT = (WIDTH_ADDR + 1)'(SIZE);

   // Elaboration-time parameter sanity checks.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("apb_mem_master: FIFO_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_mem_master: TIMEOUT_CYCLES must be >= 1");
   end

   // Addresses beyond the slave's word count are still issued; the slave
   // returns 0 and the response is flagged.
   function automatic logic addr_out_of_range(input logic [WIDTH_ADDR-1:0] a);
      return ({1'b0, a} >= SIZE_EXT);
   endfunction

   apb_mst_states state;
   apb_mst_states nxt_state;

   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [CMD_W-1:0] fifo_din;
   logic [CMD_W-1:0] fifo_dout;

   logic                  head_write;
   logic [WIDTH_ADDR-1:0] head_addr;
   logic [WIDTH_DATA-1:0] head_wdata;

   logic rsp_free;
   logic start_xfer;
   logic xfer_done;
   logic timeout_hit;

   // ---------------- command queue ----------------
   assign cmd_ready = PRESETn && !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;
   assign fifo_din  = {cmd_write, cmd_addr, cmd_wdata};
   assign fifo_pop  = start_xfer;

   assign head_write = fifo_dout[CMD_W-1];
   assign head_addr  = fifo_dout[WIDTH_DATA +: WIDTH_ADDR];
   assign head_wdata = fifo_dout[WIDTH_DATA-1:0];

   apb_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .din     (fifo_din),
      .dout    (fifo_dout)
   );

   // A new transfer may start only if its response will have somewhere to
   // land: the response register is empty or being drained this cycle.
   assign rsp_free   = !rsp_valid || rsp_ready;
   assign start_xfer = (state == apb_mst_idle) && !fifo_empty && rsp_free;
   assign xfer_done  = (state == apb_mst_access) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Cleared in SETUP so it reads 0 on the first ACCESS cycle; the abort
   // fires at the end of the TIMEOUT_CYCLES-th stalled ACCESS cycle.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         tmo_cnt <= '0;
      end else if (state == apb_mst_setup) begin
         tmo_cnt <= '0;
      end else if (state == apb_mst_access && !PREADY) begin
         tmo_cnt <= tmo_cnt + TMO_ONE;
      end
   end

   assign timeout_hit = (state == apb_mst_access) && !PREADY && (tmo_cnt == TMO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // ---------------- state register ----------------
   always_ff @(posedge PCLK) begin
      if (!PRESETn) state <= apb_mst_idle;
      else          state <= nxt_state;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      nxt_state = state;
      unique case (state)
         apb_mst_idle:   if (start_xfer) nxt_state = apb_mst_setup;
         apb_mst_setup:  nxt_state = apb_mst_access;
         apb_mst_access: if (xfer_done || timeout_hit) nxt_state = apb_mst_idle;
         default:        nxt_state = apb_mst_idle;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      case (state)
         apb_mst_setup:  PSEL = 1'b1;
         apb_mst_access: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         default: ;
      endcase
   end

   // Address/direction/data are loaded once at pop and held through
   // SETUP and ACCESS, which keeps them stable while the slave waits.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         PWRITE <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
      end else if (start_xfer) begin
         PWRITE <= head_write;
         PADDR  <= head_addr;
         PWDATA <= head_wdata;
      end
   end

   // ---------------- response register ----------------
   // Completion and acceptance never coincide: a transfer only starts once
   // the previous response is gone, so rsp_valid is 0 throughout ACCESS.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (xfer_done) begin
         rsp_valid <= 1'b1;
         rsp_write <= PWRITE;
         rsp_rdata <= PWRITE ? '0 : PRDATA;
         rsp_err   <= addr_out_of_range(PADDR);
      end else if (timeout_hit) begin
         rsp_valid <= 1'b1;
         rsp_write <= PWRITE;
         rsp_rdata <= '0;
         rsp_err   <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_apb_mem_master.sv
module tb_apb_mem_master;
   import mem_design_pkg::*;

   localparam int DW = param_WIDTH_DATA;
   localparam int AW = param_WIDTH_ADDR;
   localparam int SW = $clog2(param_SIZE);

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          PSEL, PENABLE, PWRITE, PREADY;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   apb_mem_master dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_write (rsp_write),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PREADY    (PREADY),
      .PRDATA    (PRDATA)
   );

   // Behavioural APB memory slave: one wait cycle in ACCESS, PREADY high
   // while idle, out-of-range reads return 0, cleared by PRESETn.
   logic [DW-1:0] smem [param_SIZE];
   logic          acc_seen;
   logic          stall;
   logic          in_range;

   assign in_range = int'(PADDR) < param_SIZE;
   assign PREADY   = stall ? 1'b0 : (!(PSEL && PENABLE) || acc_seen);
   assign PRDATA   = (PSEL && in_range) ? smem[PADDR[SW-1:0]] : '0;

   always @(posedge PCLK) begin
      if (!PRESETn) begin
         acc_seen <= 1'b0;
         for (int i = 0; i < param_SIZE; i++) smem[i] <= '0;
      end else begin
         acc_seen <= PSEL && PENABLE && !acc_seen;
         if (PSEL && PENABLE && PREADY && PWRITE && in_range)
            smem[PADDR[SW-1:0]] <= PWDATA;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Bus protocol monitor: PENABLE low on the PSEL rising cycle and high on
   // the next; optionally the idle gap between consecutive transfers.
   logic psel_d    = 1'b0;
   logic rise_d    = 1'b0;
   logic fall_seen = 1'b0;
   logic gap_mon   = 1'b0;
   int   gap_len   = 0;

   always @(negedge PCLK) begin
      if (PSEL && !psel_d) begin
         check("setup PENABLE", PENABLE, 0);
         if (gap_mon && fall_seen) check("psel gap", gap_len, 1);
      end
      if (rise_d) check("access PENABLE", PENABLE, 1);
      if (!gap_mon)            fall_seen <= 1'b0;
      else if (!PSEL && psel_d) fall_seen <= 1'b1;
      gap_len <= PSEL ? 0 : gap_len + 1;
      rise_d  <= PSEL && !psel_d;
      psel_d  <= PSEL;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin
         @(negedge PCLK);
         n++;
      end
      check("cmd_ready wait", cmd_ready, 1);
      @(negedge PCLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 200) begin
         @(negedge PCLK);
         lat++;
      end
      check("rsp_valid wait", rsp_valid, 1);
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vecs [8];
   vec_t fullq [5];

   initial begin
      int   lat;
      int   acc;
      logic psel_seen;

      vecs[0] = '{1'b1, 8'd5,   32'h0000_00A5, 32'h0,          1'b0};
      vecs[1] = '{1'b0, 8'd5,   32'h0,         32'h0000_00A5,  1'b0};
      vecs[2] = '{1'b1, 8'd3,   32'h0000_1234, 32'h0,          1'b0};
      vecs[3] = '{1'b0, 8'd3,   32'h0,         32'h0000_1234,  1'b0};
      vecs[4] = '{1'b0, 8'd16,  32'h0,         32'h0,          1'b1};
      vecs[5] = '{1'b1, 8'd20,  32'h0000_DEAD, 32'h0,          1'b1};
      vecs[6] = '{1'b0, 8'd15,  32'h0,         32'h0,          1'b0};
      vecs[7] = '{1'b0, 8'd255, 32'h0,         32'h0,          1'b1};

      fullq[0] = '{1'b1, 8'd1, 32'h11, 32'h0,  1'b0};
      fullq[1] = '{1'b1, 8'd2, 32'h22, 32'h0,  1'b0};
      fullq[2] = '{1'b0, 8'd1, 32'h0,  32'h11, 1'b0};
      fullq[3] = '{1'b0, 8'd2, 32'h0,  32'h22, 1'b0};
      fullq[4] = '{1'b1, 8'd7, 32'h77, 32'h0,  1'b0};

      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b1;
      stall     = 1'b0;
      repeat (3) @(negedge PCLK);

      check("reset PSEL",      PSEL,      0);
      check("reset PENABLE",   PENABLE,   0);
      check("reset PWRITE",    PWRITE,    0);
      check("reset PADDR",     PADDR,     0);
      check("reset PWDATA",    PWDATA,    0);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset rsp_write", rsp_write, 0);
      check("reset rsp_err",   rsp_err,   0);
      check("reset rsp_rdata", rsp_rdata, 0);
      check("reset cmd_ready", cmd_ready, 0);

      PRESETn = 1'b1;
      @(negedge PCLK);
      check("post-reset cmd_ready", cmd_ready, 1);

      // Directed single-command vectors, each into an empty FIFO.
      for (int i = 0; i < 8; i++) begin
         send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         wait_rsp(lat);
         check($sformatf("vec%0d latency", i), lat, 4);
         check($sformatf("vec%0d rsp_write", i), rsp_write, vecs[i].wr);
         check($sformatf("vec%0d rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d rsp_err", i), rsp_err, vecs[i].exp_err);
         @(negedge PCLK);
      end

      // Response backpressure: second queued command must wait.
      rsp_ready = 1'b0;
      send_cmd(1'b0, 8'd5, 32'h0);
      send_cmd(1'b0, 8'd3, 32'h0);
      wait_rsp(lat);
      check("bp first rdata", rsp_rdata, 32'hA5);
      psel_seen = 1'b0;
      repeat (8) begin
         @(negedge PCLK);
         if (PSEL) psel_seen = 1'b1;
      end
      check("bp no transfer while held", psel_seen, 0);
      check("bp rsp_valid held", rsp_valid, 1);
      check("bp rsp_rdata held", rsp_rdata, 32'hA5);
      rsp_ready = 1'b1;
      @(negedge PCLK);
      check("bp start same cycle PSEL", PSEL, 1);
      check("bp start same cycle PENABLE", PENABLE, 0);
      check("bp rsp consumed", rsp_valid, 0);
      wait_rsp(lat);
      check("bp second rdata", rsp_rdata, 32'h1234);
      check("bp second err", rsp_err, 0);
      @(negedge PCLK);

      // Fill the FIFO behind a stuck response, then drain in order.
      rsp_ready = 1'b0;
      send_cmd(fullq[0].wr, fullq[0].addr, fullq[0].wdata);
      wait_rsp(lat);
      for (int k = 1; k < 5; k++) begin
         cmd_write = fullq[k].wr;
         cmd_addr  = fullq[k].addr;
         cmd_wdata = fullq[k].wdata;
         cmd_valid = 1'b1;
         check($sformatf("fill%0d cmd_ready", k), cmd_ready, 1);
         @(negedge PCLK);
      end
      cmd_valid = 1'b0;
      check("fifo full cmd_ready", cmd_ready, 0);
      gap_mon   = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_rsp(lat);
         check($sformatf("drain%0d rsp_write", k), rsp_write, fullq[k].wr);
         check($sformatf("drain%0d rsp_rdata", k), rsp_rdata, fullq[k].exp_rdata);
         check($sformatf("drain%0d rsp_err", k), rsp_err, fullq[k].exp_err);
         @(negedge PCLK);
      end
      gap_mon = 1'b0;
      check("drained cmd_ready", cmd_ready, 1);

      // Reset in the middle of ACCESS with a second command queued.
      send_cmd(1'b0, 8'd5, 32'h0);
      send_cmd(1'b0, 8'd3, 32'h0);
      lat = 0;
      while (!(PSEL && PENABLE) && lat < 50) begin
         @(negedge PCLK);
         lat++;
      end
      check("reached ACCESS", PSEL && PENABLE, 1);
      PRESETn = 1'b0;
      @(negedge PCLK);
      check("mid reset PSEL", PSEL, 0);
      check("mid reset PENABLE", PENABLE, 0);
      check("mid reset rsp_valid", rsp_valid, 0);
      check("mid reset cmd_ready", cmd_ready, 0);
      PRESETn = 1'b1;
      psel_seen = 1'b0;
      repeat (4) begin
         @(negedge PCLK);
         if (PSEL || rsp_valid) psel_seen = 1'b1;
      end
      check("fifo emptied by reset", psel_seen, 0);
      send_cmd(1'b0, 8'd5, 32'h0);
      wait_rsp(lat);
      check("post-reset read latency", lat, 4);
      check("post-reset read rdata", rsp_rdata, 32'h0);
      check("post-reset read err", rsp_err, 0);
      @(negedge PCLK);

`ifdef APB_MASTER_TIMEOUT_EN
      // Slave never answers: the requester must abort after 16 ACCESS cycles.
      stall = 1'b1;
      send_cmd(1'b0, 8'd5, 32'h0);
      acc = 0;
      lat = 0;
      while (!rsp_valid && lat < 200) begin
         @(negedge PCLK);
         if (PSEL && PENABLE) acc++;
         lat++;
      end
      check("timeout rsp_valid", rsp_valid, 1);
      check("timeout access cycles", acc, 16);
      check("timeout rsp_err", rsp_err, 1);
      check("timeout rsp_rdata", rsp_rdata, 32'h0);
      check("timeout PSEL dropped", PSEL, 0);
      stall = 1'b0;
      @(negedge PCLK);
`else
      acc = 0;
      check("no-timeout idle", PSEL + acc, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
